// File: rtl/letreiro_pkg.sv
// Shared definitions for the scrolling sign: character codes, the fixed
// message table and the sequencer state encoding.
package letreiro_pkg;

   localparam logic [2:0] C_G      = 3'b100;
   localparam logic [2:0] C_A      = 3'b101;
   localparam logic [2:0] C_B      = 3'b110;
   localparam logic [2:0] C_R      = 3'b111;
   localparam logic [2:0] C_I      = 3'b000;
   localparam logic [2:0] C_E      = 3'b001;
   localparam logic [2:0] C_L      = 3'b010;
   localparam logic [2:0] C_ESPACO = 3'b011;

   localparam int MSG_LEN = 8;

   // "gabriel " with index 0 in the least significant slot.
   localparam logic [7:0][2:0] MSG = {C_ESPACO, C_L, C_E, C_I, C_R, C_B, C_A, C_G};

   typedef enum logic {
      PARADO,
      ROLANDO
   } estado_t;

   function automatic logic [2:0] msg_char(input logic [2:0] idx);
      return MSG[idx];
   endfunction

endpackage

// File: rtl/letreiro_prescaler.sv
// Scroll-rate prescaler: counts 0..DIV-1 and flags the terminal count.
// A synchronous clear holds it at zero.
module letreiro_prescaler #(
   parameter int DIV = 25_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic fim
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [W-1:0] contagem;

   assign fim = (contagem == W'(DIV - 1));

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         contagem <= '0;
      end else if (fim) begin
         contagem <= '0;
      end else begin
         contagem <= contagem + 1'b1;
      end
   end

endmodule

// File: rtl/letreiro_sequenciador.sv
// Scrolling-message sequencer: run/stop FSM, position register, step edge
// detector and the per-display character codes.
module letreiro_sequenciador
   import letreiro_pkg::*;
#(
   parameter int N_DISP = 4,
   parameter int DIV    = 25_000_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  habilita,
   input  logic                  direcao,
   input  logic                  passo,
   output logic [3*N_DISP-1:0]   codigos,
   output logic [2:0]            posicao,
   output logic                  tick
);

   estado_t               estado;
   estado_t               estado_prox;
   logic                  passo_prev;
   logic                  avanca;
   logic                  fim;
   logic                  limpa;
   logic [2:0]            posicao_prox;
   logic [3*N_DISP-1:0]   codigos_prox;
   logic [3*N_DISP-1:0]   codigos_rst;

   // Prescaler only runs while scrolling with habilita still high.
   assign limpa = (estado != ROLANDO) || !habilita;

   letreiro_prescaler #(
      .DIV (DIV)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clear (limpa),
      .fim   (fim)
   );

   // habilita takes priority over a simultaneous step request.
   always_comb begin
      estado_prox = estado;
      avanca      = 1'b0;
      case (estado)
         PARADO: begin
            if (habilita) begin
               estado_prox = ROLANDO;
            end else if (passo && !passo_prev) begin
               avanca = 1'b1;
            end
         end
         ROLANDO: begin
            if (!habilita) begin
               estado_prox = PARADO;
            end else if (fim) begin
               avanca = 1'b1;
            end
         end
         default: estado_prox = PARADO;
      endcase
   end

   always_comb begin
      posicao_prox = posicao;
      if (avanca) begin
         posicao_prox = direcao ? (posicao - 3'd1) : (posicao + 3'd1);
      end
   end

   // Codes are derived from the next position so both register together.
   always_comb begin
      codigos_prox = '0;
      codigos_rst  = '0;
      for (int k = 0; k < N_DISP; k++) begin
         codigos_prox[3*k +: 3] = msg_char(posicao_prox + 3'(k));
         codigos_rst[3*k +: 3]  = msg_char(3'(k));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado     <= PARADO;
         posicao    <= 3'd0;
         passo_prev <= 1'b0;
         tick       <= 1'b0;
         codigos    <= codigos_rst;
      end else begin
         estado     <= estado_prox;
         posicao    <= posicao_prox;
         passo_prev <= passo;
         tick       <= avanca;
         codigos    <= codigos_prox;
      end
   end

endmodule

// File: tb/tb_letreiro_sequenciador.sv
// Directed bench for letreiro_sequenciador with DIV=4 and four displays.
module tb_letreiro_sequenciador;

   localparam int N_DISP = 4;
   localparam int DIV    = 4;

   logic                clk = 1'b0;
   logic                reset;
   logic                habilita;
   logic                direcao;
   logic                passo;
   logic [3*N_DISP-1:0] codigos;
   logic [2:0]          posicao;
   logic                tick;

   int checks = 0;
   int errors = 0;

   letreiro_sequenciador #(
      .N_DISP (N_DISP),
      .DIV    (DIV)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .habilita (habilita),
      .direcao  (direcao),
      .passo    (passo),
      .codigos  (codigos),
      .posicao  (posicao),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] codes_of(input int p);
      logic [2:0] tbl [8];
      logic [11:0] v;
      tbl = '{3'b100, 3'b101, 3'b110, 3'b111, 3'b000, 3'b001, 3'b010, 3'b011};
      v = '0;
      for (int k = 0; k < 4; k++) begin
         v[3*k +: 3] = tbl[(p + k) % 8];
      end
      return v;
   endfunction

   task automatic applyStimulus(input logic r, input logic h, input logic d, input logic p);
      reset    = r;
      habilita = h;
      direcao  = d;
      passo    = p;
   endtask

   task automatic checkValue(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input int exp_pos, input logic exp_tick);
      checkValue({tag, ".posicao"}, {9'd0, posicao}, 12'(exp_pos));
      checkValue({tag, ".tick"},    {11'd0, tick},   {11'd0, exp_tick});
      checkValue({tag, ".codigos"}, codigos,         codes_of(exp_pos));
   endtask

   // Waits n_before cycles with no change, then expects the advance to new_pos.
   task automatic checkStep(input int old_pos, input int new_pos, input int n_before, input bit toggle);
      for (int i = 0; i < n_before; i++) begin
         if (toggle) passo = ~passo;
         @(negedge clk);
         checkOutput("hold", old_pos, 1'b0);
      end
      if (toggle) passo = ~passo;
      @(negedge clk);
      checkOutput("step", new_pos, 1'b1);
   endtask

   initial begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      checkValue("reset.codigos", codigos, 12'b111_110_101_100);
      checkOutput("reset", 0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkValue("idle.tick", {11'd0, tick}, 12'd0);
      end
      checkOutput("idle", 0, 1'b0);

      // Automatic scroll left through a full wrap.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkStep(0, 1, 4, 1'b0);
      for (int p = 1; p < 8; p++) begin
         checkStep(p, (p + 1) % 8, 3, 1'b0);
         if (p + 1 == 5) checkValue("pos5.codigos", codigos, 12'b100_011_010_001);
      end

      // Stop, then single-step right with passo held high.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3) begin
         @(negedge clk);
         checkOutput("stop", 0, 1'b0);
      end
      passo = 1'b1;
      @(negedge clk);
      checkOutput("passo7", 7, 1'b1);
      checkValue("passo7.codigos", codigos, 12'b110_101_100_011);
      repeat (5) begin
         @(negedge clk);
         checkOutput("passo_held", 7, 1'b0);
      end
      passo = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("passo_low", 7, 1'b0);
      passo = 1'b1;
      @(negedge clk);
      checkOutput("passo6", 6, 1'b1);
      passo = 1'b0;
      @(negedge clk);

      // Drop habilita exactly on the terminal-count cycle.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (4) begin
         @(negedge clk);
         checkOutput("run_pre", 6, 1'b0);
      end
      habilita = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("drop_tc", 6, 1'b0);
      end
      habilita = 1'b1;
      checkStep(6, 7, 4, 1'b0);
      habilita = 1'b0;
      repeat (2) @(negedge clk);

      // habilita and passo rise together; passo toggling while scrolling.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      checkStep(7, 0, 4, 1'b0);
      for (int p = 0; p < 6; p++) begin
         checkStep(p, p + 1, 3, 1'b1);
      end
      passo = 1'b0;

      // Reset mid-scroll at posicao 6 with the prescaler at 2.
      @(negedge clk);
      checkOutput("pre_reset", 6, 1'b0);
      @(negedge clk);
      checkOutput("pre_reset", 6, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("mid_reset", 0, 1'b0);
      reset = 1'b0;
      checkStep(0, 1, 4, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
